// File: rtl/al_const_capture_pkg.sv
// Shared constants for the auto-load constant capture block: state encoding,
// error bit positions and default geometry of the parameter bank.
package al_const_capture_pkg;

    localparam int unsigned NWORDS_DEF = 34;
    localparam logic [15:0] HEADER_DEF = 16'hDCFE;

    typedef logic [1:0] cap_state_t;

    localparam cap_state_t ST_IDLE   = 2'd0;
    localparam cap_state_t ST_FILL   = 2'd1;
    localparam cap_state_t ST_CHECK  = 2'd2;
    localparam cap_state_t ST_COMMIT = 2'd3;

    localparam int ERR_MISSING  = 0;
    localparam int ERR_HEADER   = 1;
    localparam int ERR_CHECKSUM = 2;
    localparam int ERR_RANGE    = 3;

    // True when a 6-bit word index addresses a real slot of an nwords-deep bank.
    function automatic logic idxInRange(input logic [5:0] idx, input int unsigned nwords);
        return {26'd0, idx} < nwords;
    endfunction

endpackage

// File: rtl/al_const_capture_if.sv
// Sequencer-to-capture handshake: control pulses plus the flash word stream.
interface al_const_capture_if;

    logic        al_start;
    logic        al_done;
    logic        al_abort;
    logic        bpi_load_data;
    logic [15:0] bpi_al_reg;
    logic [22:0] al_addr;

    modport master (
        output al_start, al_done, al_abort, bpi_load_data, bpi_al_reg, al_addr
    );

    modport slave (
        input al_start, al_done, al_abort, bpi_load_data, bpi_al_reg, al_addr
    );

endinterface

// File: rtl/al_const_ram.sv
// NWORDS x 16 word store with one write port and one registered read port.
// Reads past the last word return zero; reset clears the whole array.
module al_const_ram
    import al_const_capture_pkg::*;
#(
    parameter int unsigned NWORDS = NWORDS_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_i,
    input  logic [5:0]  waddr_i,
    input  logic [15:0] wdata_i,
    input  logic [5:0]  raddr_i,
    output logic [15:0] rdata_o
);

    logic [15:0] mem_q [NWORDS];
    logic [15:0] rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NWORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && idxInRange(waddr_i, NWORDS)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= idxInRange(raddr_i, NWORDS) ? mem_q[raddr_i] : 16'h0000;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/al_const_capture.sv
// Captures auto-loaded flash parameter words into a shadow bank, validates them
// (coverage, header, checksum) and only then copies them into the live bank.
module al_const_capture
    import al_const_capture_pkg::*;
#(
    parameter int unsigned NWORDS = NWORDS_DEF,
    parameter logic [15:0] HEADER = HEADER_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    al_const_capture_if.slave  seq,
    input  logic [5:0]         const_raddr_i,
    output logic [15:0]        const_rdata_o,
    output logic               const_valid_o,
    output logic               const_update_o,
    output logic               cap_busy_o,
    output logic [5:0]         cap_wcnt_o,
    output logic [3:0]         cap_err_o
);

    localparam logic [6:0] NW7   = 7'(NWORDS);
    localparam logic [6:0] LAST7 = 7'(NWORDS - 1);

    cap_state_t  state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [15:0] sum_q, sum_d;
    logic        hdrOk_q, hdrOk_d;
    logic [63:0] bitmap_q, bitmap_d;
    logic [5:0]  wcnt_q, wcnt_d;
    logic [3:0]  err_q, err_d;
    logic        valid_q, valid_d;
    logic        update_q, update_d;

    logic [5:0]  loadIdx;
    logic        shWe;
    logic [5:0]  shRaddr;
    logic [15:0] shRdata;
    logic        lvWe;
    logic        unusedAddrHi;

    assign loadIdx      = seq.al_addr[5:0];
    assign unusedAddrHi = ^seq.al_addr[22:6];

    // The shadow read port lags its address by a cycle. CHECK walks it with
    // cnt_q (sum lags one step, so CHECK spans NWORDS+1 cycles), while COMMIT
    // prefetches with cnt_d so live[cnt_q] is written with shadow[cnt_q].
    assign shRaddr = (state_d == ST_COMMIT) ? cnt_d[5:0] : cnt_q[5:0];
    assign lvWe    = (state_q == ST_COMMIT);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        hdrOk_d  = hdrOk_q;
        bitmap_d = bitmap_q;
        wcnt_d   = wcnt_q;
        err_d    = err_q;
        valid_d  = valid_q;
        update_d = 1'b0;
        shWe     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (seq.al_start) begin
                    state_d  = ST_FILL;
                    bitmap_d = '0;
                    wcnt_d   = '0;
                    err_d    = '0;
                end
            end
            ST_FILL: begin
                if (seq.al_abort) begin
                    state_d = ST_IDLE;
                end else begin
                    if (seq.bpi_load_data) begin
                        if (idxInRange(loadIdx, NWORDS)) begin
                            shWe              = 1'b1;
                            bitmap_d[loadIdx] = 1'b1;
                            if (!bitmap_q[loadIdx]) begin
                                wcnt_d = wcnt_q + 6'd1;
                            end
                        end else begin
                            err_d[ERR_RANGE] = 1'b1;
                        end
                    end
                    if (seq.al_done) begin
                        state_d = ST_CHECK;
                        cnt_d   = '0;
                        sum_d   = '0;
                    end
                end
            end
            ST_CHECK: begin
                if (seq.al_abort) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                    if (cnt_q != 7'd0) begin
                        sum_d = sum_q + shRdata;
                    end
                    if (cnt_q == 7'd1) begin
                        hdrOk_d = (shRdata == HEADER);
                    end
                    if (cnt_q == NW7) begin
                        err_d[ERR_MISSING]  = ~&bitmap_q[NWORDS-1:0];
                        err_d[ERR_HEADER]   = ~hdrOk_q;
                        err_d[ERR_CHECKSUM] = (sum_d != 16'h0000);
                        if (err_d != 4'b0000) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_COMMIT;
                            cnt_d   = '0;
                            valid_d = 1'b0;
                        end
                    end
                end
            end
            ST_COMMIT: begin
                cnt_d = cnt_q + 7'd1;
                if (cnt_q == LAST7) begin
                    state_d  = ST_IDLE;
                    valid_d  = 1'b1;
                    update_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sum_q    <= '0;
            hdrOk_q  <= 1'b0;
            bitmap_q <= '0;
            wcnt_q   <= '0;
            err_q    <= '0;
            valid_q  <= 1'b0;
            update_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            hdrOk_q  <= hdrOk_d;
            bitmap_q <= bitmap_d;
            wcnt_q   <= wcnt_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
            update_q <= update_d;
        end
    end

    al_const_ram #(.NWORDS(NWORDS)) u_shadow (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (shWe),
        .waddr_i (loadIdx),
        .wdata_i (seq.bpi_al_reg),
        .raddr_i (shRaddr),
        .rdata_o (shRdata)
    );

    al_const_ram #(.NWORDS(NWORDS)) u_live (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (lvWe),
        .waddr_i (cnt_q[5:0]),
        .wdata_i (shRdata),
        .raddr_i (const_raddr_i),
        .rdata_o (const_rdata_o)
    );

    assign const_valid_o  = valid_q;
    assign const_update_o = update_q;
    assign cap_busy_o     = (state_q != ST_IDLE);
    assign cap_wcnt_o     = wcnt_q;
    assign cap_err_o      = err_q;

endmodule

// File: tb/tb_al_const_capture.sv
// Self-checking bench for al_const_capture: scripted and randomized loads are
// scored against a word-level model of the shadow and live banks.
module tb_al_const_capture;

    localparam int          NW  = 34;
    localparam logic [15:0] HDR = 16'hDCFE;

    logic        clk;
    logic        rst_n;
    logic [5:0]  const_raddr;
    logic [15:0] const_rdata;
    logic        const_valid;
    logic        const_update;
    logic        cap_busy;
    logic [5:0]  cap_wcnt;
    logic [3:0]  cap_err;

    al_const_capture_if bus ();

    al_const_capture dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .seq            (bus),
        .const_raddr_i  (const_raddr),
        .const_rdata_o  (const_rdata),
        .const_valid_o  (const_valid),
        .const_update_o (const_update),
        .cap_busy_o     (cap_busy),
        .cap_wcnt_o     (cap_wcnt),
        .cap_err_o      (cap_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int asserts  = 0;
    int failures = 0;

    // Model state: what the shadow and live banks should hold.
    logic [15:0] shadowM [64];
    logic [15:0] liveM   [64];
    bit          validM;

    int          loadIdx  [$];
    logic [15:0] loadData [$];

    task automatic clearModel();
        for (int i = 0; i < 64; i++) begin
            shadowM[i] = '0;
            liveM[i]   = '0;
        end
        validM = 1'b0;
    endtask

    task automatic buildBase(input int skip);
        loadIdx.delete();
        loadData.delete();
        for (int i = 0; i < NW - 1; i++) begin
            if (i != skip) begin
                loadIdx.push_back(i);
                loadData.push_back((i == 0) ? HDR : 16'($urandom));
            end
        end
    endtask

    task automatic shuffleLoad();
        int          j, ti;
        logic [15:0] td;
        for (int i = loadIdx.size() - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            ti = loadIdx[i];  loadIdx[i]  = loadIdx[j];  loadIdx[j]  = ti;
            td = loadData[i]; loadData[i] = loadData[j]; loadData[j] = td;
        end
    endtask

    // Append the final word so the bank, as it will stand after this load, sums to zero.
    task automatic fixChecksum();
        logic [15:0] tmp [64];
        logic [15:0] s;
        tmp = shadowM;
        foreach (loadIdx[i]) if (loadIdx[i] < NW) tmp[loadIdx[i]] = loadData[i];
        s = '0;
        for (int i = 0; i < NW - 1; i++) s += tmp[i];
        loadIdx.push_back(NW - 1);
        loadData.push_back(16'h0000 - s);
    endtask

    task automatic checkLive(input string name);
        int addrs [$];
        logic [15:0] expCur, expPrev;
        for (int i = 0; i < NW; i++) addrs.push_back(i);
        addrs.push_back(40);
        addrs.push_back(63);
        addrs.push_back(NW);
        expPrev = '0;
        foreach (addrs[k]) begin
            @(negedge clk);
            const_raddr = 6'(addrs[k]);
            expCur = (addrs[k] < NW) ? liveM[addrs[k]] : 16'h0000;
            #1;
            if (k > 0) begin
                asserts++;
                if (const_rdata !== expPrev) begin
                    failures++;
                    $display("[TB] FAIL %s rdata_latency addr=%0d: got %h expected %h", name, addrs[k], const_rdata, expPrev);
                end
            end
            @(posedge clk);
            #1;
            asserts++;
            if (const_rdata !== expCur) begin
                failures++;
                $display("[TB] FAIL %s rdata addr=%0d: got %h expected %h", name, addrs[k], const_rdata, expCur);
            end
            expPrev = expCur;
        end
    endtask

    // mode: 0 normal, 1 abort held during commit, 2 reset during commit.
    // abortAfter >= 0 aborts the fill after that many words.
    task automatic runLoad(input string name, input bit lastWithDone, input int abortAfter, input int mode);
        logic [15:0] tmp [64];
        bit          written [64];
        int          wc, nApplied, n, updCycle, updCount, nLast;
        bit          rangeErr, missing;
        logic [15:0] s;
        logic [3:0]  expErr;

        tmp = shadowM;
        for (int i = 0; i < 64; i++) written[i] = 1'b0;
        wc = 0;
        rangeErr = 1'b0;
        nApplied = (abortAfter >= 0) ? abortAfter : loadIdx.size();
        for (int i = 0; i < nApplied; i++) begin
            if (loadIdx[i] < NW) begin
                tmp[loadIdx[i]] = loadData[i];
                if (!written[loadIdx[i]]) wc++;
                written[loadIdx[i]] = 1'b1;
            end else begin
                rangeErr = 1'b1;
            end
        end
        shadowM = tmp;
        if (abortAfter >= 0) begin
            expErr = {rangeErr, 3'b000};
        end else begin
            s = '0;
            missing = 1'b0;
            for (int i = 0; i < NW; i++) begin
                s += tmp[i];
                if (!written[i]) missing = 1'b1;
            end
            expErr = {rangeErr, (s != 16'h0000), (tmp[0] != HDR), missing};
        end

        @(negedge clk);
        bus.al_start = 1'b1;
        @(negedge clk);
        bus.al_start = 1'b0;
        asserts++;
        if (cap_busy !== 1'b1 || cap_wcnt !== 6'd0 || cap_err !== 4'd0) begin
            failures++;
            $display("[TB] FAIL %s start_state: got busy=%b wcnt=%0d err=%b expected busy=1 wcnt=0 err=0000", name, cap_busy, cap_wcnt, cap_err);
        end

        nLast = (lastWithDone && abortAfter < 0) ? loadIdx.size() - 1 : nApplied;
        for (int i = 0; i < nLast; i++) begin
            bus.bpi_load_data = 1'b1;
            bus.bpi_al_reg    = loadData[i];
            bus.al_addr       = {17'($urandom), 6'(loadIdx[i])};
            @(negedge clk);
            bus.bpi_load_data = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        if (abortAfter >= 0) begin
            bus.al_abort = 1'b1;
            @(posedge clk);
            #1;
            asserts++;
            if (cap_busy !== 1'b0) begin
                failures++;
                $display("[TB] FAIL %s abort_busy: got %b expected 0", name, cap_busy);
            end
            bus.al_abort = 1'b0;
            updCount = 0;
            repeat (75) begin
                @(posedge clk);
                #1;
                if (const_update) updCount++;
            end
        end else begin
            if (lastWithDone) begin
                bus.bpi_load_data = 1'b1;
                bus.bpi_al_reg    = loadData[nLast];
                bus.al_addr       = {17'($urandom), 6'(loadIdx[nLast])};
            end
            bus.al_done = 1'b1;
            @(posedge clk);
            #1;
            bus.al_done       = 1'b0;
            bus.bpi_load_data = 1'b0;
            n = 0;
            updCycle = -1;
            updCount = 0;
            while (n < 90) begin
                @(posedge clk);
                n++;
                #1;
                if (mode == 1 && n == 45) bus.al_abort = 1'b1;
                if (mode == 1 && n == 50) bus.al_abort = 1'b0;
                if (const_update) begin
                    updCount++;
                    if (updCycle < 0) updCycle = n;
                end
                if (n == 45 && expErr == 4'd0) begin
                    asserts++;
                    if (const_valid !== 1'b0 || cap_busy !== 1'b1) begin
                        failures++;
                        $display("[TB] FAIL %s commit_state: got valid=%b busy=%b expected valid=0 busy=1", name, const_valid, cap_busy);
                    end
                end
                if (mode == 2 && n == 50) begin
                    #2;
                    rst_n = 1'b0;
                    #1;
                    asserts++;
                    if (const_valid !== 1'b0 || const_update !== 1'b0 || cap_busy !== 1'b0 ||
                        cap_wcnt !== 6'd0 || cap_err !== 4'd0 || const_rdata !== 16'h0000) begin
                        failures++;
                        $display("[TB] FAIL %s async_reset: got valid=%b upd=%b busy=%b wcnt=%0d err=%b rdata=%h expected all zero",
                                 name, const_valid, const_update, cap_busy, cap_wcnt, cap_err, const_rdata);
                    end
                    clearModel();
                    @(negedge clk);
                    rst_n = 1'b1;
                    break;
                end
            end
        end

        if (mode != 2) begin
            if (abortAfter < 0 && expErr == 4'd0) begin
                asserts++;
                if (updCycle != 2 * NW + 1 || updCount != 1) begin
                    failures++;
                    $display("[TB] FAIL %s update_latency: got cycle=%0d pulses=%0d expected cycle=%0d pulses=1", name, updCycle, updCount, 2 * NW + 1);
                end
                for (int i = 0; i < NW; i++) liveM[i] = shadowM[i];
                validM = 1'b1;
            end else begin
                asserts++;
                if (updCount != 0) begin
                    failures++;
                    $display("[TB] FAIL %s no_update: got %0d pulses expected 0", name, updCount);
                end
            end
            asserts++;
            if (cap_err !== expErr) begin
                failures++;
                $display("[TB] FAIL %s cap_err: got %b expected %b", name, cap_err, expErr);
            end
            asserts++;
            if (cap_wcnt !== 6'(wc)) begin
                failures++;
                $display("[TB] FAIL %s cap_wcnt: got %0d expected %0d", name, cap_wcnt, wc);
            end
            asserts++;
            if (const_valid !== validM || cap_busy !== 1'b0) begin
                failures++;
                $display("[TB] FAIL %s end_state: got valid=%b busy=%b expected valid=%b busy=0", name, const_valid, cap_busy, validM);
            end
        end
        checkLive(name);
    endtask

    task automatic test_reset();
        asserts++;
        if (const_valid !== 1'b0 || const_update !== 1'b0 || cap_busy !== 1'b0 ||
            cap_wcnt !== 6'd0 || cap_err !== 4'd0 || const_rdata !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL reset: got valid=%b upd=%b busy=%b wcnt=%0d err=%b rdata=%h expected all zero",
                     const_valid, const_update, cap_busy, cap_wcnt, cap_err, const_rdata);
        end
        checkLive("reset_read");
    endtask

    task automatic test_valid_load();
        buildBase(-1);
        fixChecksum();
        runLoad("valid_load", 1'b1, -1, 0);
    endtask

    task automatic test_bad_checksum();
        buildBase(-1);
        fixChecksum();
        loadData[loadData.size() - 1] = loadData[loadData.size() - 1] + 16'd1;
        runLoad("bad_checksum", 1'b0, -1, 0);
    endtask

    task automatic test_missing_range();
        buildBase(17);
        loadIdx.push_back(40);
        loadData.push_back(16'($urandom));
        fixChecksum();
        runLoad("missing_range", 1'b0, -1, 0);
    endtask

    task automatic test_duplicate();
        buildBase(-1);
        loadData[5] = 16'h1111;
        loadIdx.push_back(5);
        loadData.push_back(16'h2222);
        fixChecksum();
        runLoad("duplicate", 1'b0, -1, 0);
    endtask

    task automatic test_abort();
        buildBase(-1);
        fixChecksum();
        runLoad("abort_fill", 1'b0, 10, 0);
        buildBase(-1);
        fixChecksum();
        runLoad("abort_commit", 1'b0, -1, 1);
    endtask

    task automatic test_reset_commit();
        buildBase(-1);
        fixChecksum();
        runLoad("reset_commit", 1'b0, -1, 2);
    endtask

    task automatic test_random();
        int kind;
        for (int r = 0; r < 4; r++) begin
            kind = $urandom_range(0, 3);
            buildBase((kind == 1) ? int'($urandom_range(1, NW - 2)) : -1);
            if (kind == 2) loadData[0] = HDR ^ 16'h0100;
            if (kind == 3) begin
                loadIdx.push_back($urandom_range(NW, 63));
                loadData.push_back(16'($urandom));
            end
            loadIdx.push_back($urandom_range(0, NW - 2));
            loadData.push_back(16'($urandom));
            shuffleLoad();
            fixChecksum();
            runLoad($sformatf("random%0d_kind%0d", r, kind), 1'(r & 1), -1, 0);
        end
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.al_start      = 1'b0;
        bus.al_done       = 1'b0;
        bus.al_abort      = 1'b0;
        bus.bpi_load_data = 1'b0;
        bus.bpi_al_reg    = '0;
        bus.al_addr       = '0;
        const_raddr       = '0;
        clearModel();
        repeat (3) @(negedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_valid_load();
        test_bad_checksum();
        test_missing_range();
        test_duplicate();
        test_abort();
        test_reset_commit();
        test_valid_load();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
